// File: rtl/multiplier_datapath.sv
// multiplier_datapath
//
// Arithmetic half of a sequential unsigned multiplier. A separate controller
// walks state_i through IDLE -> PROD0..PROD3 -> END; this block captures the
// operands on the last IDLE edge and builds the WIDTH x WIDTH product from
// four HALF x HALF partial products, one per compute state.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous, active-low reset; clears every register
//   state_i    controller state code (0..5 valid, 6/7 invalid)
//   a_i, b_i   unsigned operands, sampled only while state_i == IDLE
//   product_o  registered 2*WIDTH-bit result, updated only on the PROD3 edge
//   done_o     combinational, high while state_i == END
//   busy_o     combinational, high while state_i is PROD0..PROD3
//
// There is no valid/ready handshake here: the controller owns sequencing.
// done_o qualifies product_o, and product_o stays stable until the next
// completed PROD3 edge.
module multiplier_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [2:0]           state_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [2*WIDTH-1:0]   product_o,
  output logic                 done_o,
  output logic                 busy_o
);

  localparam int HALF = WIDTH / 2;

  localparam logic [2:0] ST_IDLE          = 3'd0;
  localparam logic [2:0] ST_COMPUTE_PROD0 = 3'd1;
  localparam logic [2:0] ST_COMPUTE_PROD1 = 3'd2;
  localparam logic [2:0] ST_COMPUTE_PROD2 = 3'd3;
  localparam logic [2:0] ST_COMPUTE_PROD3 = 3'd4;
  localparam logic [2:0] ST_END           = 3'd5;

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] result_q;

  // Operand halves, zero-extended to WIDTH so each product is computed at
  // its full 2*HALF width without truncation.
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] a_h;
  logic [WIDTH-1:0] b_l;
  logic [WIDTH-1:0] b_h;

  assign a_l = {{(WIDTH-HALF){1'b0}}, a_q[HALF-1:0]};
  assign a_h = {{(WIDTH-HALF){1'b0}}, a_q[WIDTH-1:HALF]};
  assign b_l = {{(WIDTH-HALF){1'b0}}, b_q[HALF-1:0]};
  assign b_h = {{(WIDTH-HALF){1'b0}}, b_q[WIDTH-1:HALF]};

  logic [WIDTH-1:0] pp_ll;
  logic [WIDTH-1:0] pp_lh;
  logic [WIDTH-1:0] pp_hl;
  logic [WIDTH-1:0] pp_hh;

  assign pp_ll = a_l * b_l;
  assign pp_lh = a_l * b_h;
  assign pp_hl = a_h * b_l;
  assign pp_hh = a_h * b_h;

  // Partial product selected by the current compute state, already aligned
  // at 2*WIDTH bits. The running sum cannot overflow 2*WIDTH bits.
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_sum;

  always_comb begin
    addend = '0;
    case (state_i)
      ST_COMPUTE_PROD0: addend = {{WIDTH{1'b0}}, pp_ll};
      ST_COMPUTE_PROD1: addend = {{WIDTH{1'b0}}, pp_lh} << HALF;
      ST_COMPUTE_PROD2: addend = {{WIDTH{1'b0}}, pp_hl} << HALF;
      ST_COMPUTE_PROD3: addend = {{WIDTH{1'b0}}, pp_hh} << WIDTH;
      default:          addend = '0;
    endcase
  end

  assign acc_sum = acc + addend;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      result_q <= '0;
    end else begin
      case (state_i)
        ST_IDLE: begin
          // Every IDLE edge re-captures; the last one before PROD0 wins.
          a_q <= a_i;
          b_q <= b_i;
          acc <= '0;
        end
        ST_COMPUTE_PROD0,
        ST_COMPUTE_PROD1,
        ST_COMPUTE_PROD2: begin
          acc <= acc_sum;
        end
        ST_COMPUTE_PROD3: begin
          // Publish the final sum on the same edge it is formed so the
          // result is visible in the first END cycle.
          acc      <= acc_sum;
          result_q <= acc_sum;
        end
        ST_END: begin
          // hold everything
        end
        default: begin
          // Invalid code: discard any partial sum, keep operands and result.
          acc <= '0;
        end
      endcase
    end
  end

  assign product_o = result_q;
  assign done_o    = (state_i == ST_END);
  assign busy_o    = (state_i >= ST_COMPUTE_PROD0) && (state_i <= ST_COMPUTE_PROD3);

endmodule

// File: doc/multiplier_datapath.md
# multiplier_datapath

Arithmetic datapath that consumes the 3-bit state code produced by the multiplier controller and computes an unsigned WIDTH×WIDTH product as four half-width partial products, one per compute state. It sits beside the controller: the controller sequences, and this block captures operands, accumulates partial products, and presents the registered result and status flags to the surrounding logic.

## Interface
- WIDTH, 8: operand width. Must be even and ≥ 2. HALF = WIDTH/2.
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- state_i  input  3  controller state code. ST_IDLE=0, ST_COMPUTE_PROD0=1, ST_COMPUTE_PROD1=2, ST_COMPUTE_PROD2=3, ST_COMPUTE_PROD3=4, ST_END=5. Codes 6 and 7 are invalid.
- a_i  input  WIDTH  multiplicand, unsigned.
- b_i  input  WIDTH  multiplier, unsigned.
- product_o  output  2*WIDTH  registered result, unsigned.
- done_o  output  1  result valid; high while state_i==ST_END.
- busy_o  output  1  high while state_i is ST_COMPUTE_PROD0..3.

## Operation
- Internal registers:
  - a_q and b_q: WIDTH bits each.
  - acc: 2*WIDTH bits.
  - result_q: 2*WIDTH bits, drives product_o.
- Operand split: aL = a_q[HALF-1:0], aH = a_q[WIDTH-1:HALF]. bL and bH are split from b_q the same way.
- Per rising edge, the action depends on state_i:
  - ST_IDLE: a_q←a_i, b_q←b_i, acc←0. result_q holds.
  - ST_COMPUTE_PROD0: acc←acc + aL*bL.
  - ST_COMPUTE_PROD1: acc←acc + (aL*bH << HALF).
  - ST_COMPUTE_PROD2: acc←acc + (aH*bL << HALF).
  - ST_COMPUTE_PROD3: acc←acc + (aH*bH << WIDTH). result_q is loaded with the same sum in the same edge.
  - ST_END: all registers hold.
  - Invalid code (6, 7): acc←0. a_q, b_q and result_q hold.
- Arithmetic width rules:
  - Each partial product is 2*HALF bits, zero-extended to 2*WIDTH before shifting.
  - All sums are carried at 2*WIDTH bits and cannot overflow, because the final value ≤ (2^WIDTH−1)^2.
- Operand capture:
  - Operands are sampled on the last ST_IDLE edge, which is the edge where the controller moves to PROD0.
  - a_i and b_i are ignored in every other state.
- Flags:
  - done_o = (state_i==ST_END), combinational.
  - busy_o = (state_i∈{1,2,3,4}), combinational.
  - Both are 0 for codes 0, 6 and 7.
- Hold behaviour: product_o keeps the last completed result through ST_END, ST_IDLE and any later incomplete computation, until the next PROD3 edge.
- Aborted sequence (state_i returns to ST_IDLE before PROD3):
  - acc is cleared on the next edge.
  - result_q is not updated.

## Timing
- Reset (rst_i=0, asynchronous), all registers go to 0:
  - product_o=0, a_q=0, b_q=0, acc=0.
  - done_o and busy_o follow state_i. The controller holds ST_IDLE during reset, so both read 0.
- Reset mid-operation: all registers clear immediately. The first post-reset computation starts from acc=0.
- Latency, counting edge E0 as the IDLE→PROD0 edge (operands captured):
  - Edges E1 through E4 execute PROD0 through PROD3.
  - product_o is valid immediately after E4, the same cycle done_o rises.
  - Start sampled to result valid is 5 edges.
- ST_END is held while the controller's start input stays high. product_o remains stable for that whole time.
- Back-to-back operation: there is no minimum IDLE dwell beyond one cycle. One IDLE edge is enough to capture new operands.

## Test plan
- Basic product: WIDTH=8, a_i=0x12, b_i=0x34, start pulse. product_o=0x03A8 on the first ST_END cycle; busy_o high for exactly 4 cycles; done_o high in ST_END.
- Maximum operands: a_i=0xFF, b_i=0xFF → product_o=0xFE01. Zero operand: a_i=0x00, b_i=0xAB → product_o=0x0000, which overwrites the previous result.
- Operand isolation: capture a_i=0x0F, b_i=0x10, then drive a_i=b_i=0xFF during PROD0–PROD3 → product_o=0x00F0.
- Reset mid-compute: assert rst_i during PROD2 → product_o=0 immediately. The next run, 0x03×0x05, gives product_o=0x000F.
- Invalid code and hold:
  - After a result of 0x03A8, drive state_i=6 for 2 cycles, then run 0x02×0x03 → product_o=0x0006.
  - During the invalid cycles: done_o=0, busy_o=0, product_o still 0x03A8.
- Abort: run 0x12×0x34, then force state_i from PROD1 back to IDLE → product_o keeps its previous value. The next full run, 0x07×0x09, gives 0x003F.
